// File: rtl/keypad_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : keypad_alu_datapath
// Brief    : 4x4 keypad scanner with frame debounce, plus a 3-cycle
//            register-file ALU with registered flags. Define KALU_SAT_EN to
//            saturate ADD/SUB results.
// Revision : 1.0
// ============================================================================
module keypad_alu_datapath #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 3,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        key_rows,
    output logic [3:0]        key_cols,
    output logic              key_valid,
    output logic [3:0]        key_code,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              res_valid,
    output logic [WIDTH-1:0]  res_data,
    output logic [3:0]        flags
);

`ifdef KALU_SAT_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    localparam int c_DWELL_W = $clog2(SCAN_DIV);
    localparam int c_DB_W    = $clog2(DEBOUNCE + 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SHR = 3'b110;
    localparam logic [2:0] c_OP_LDK = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Keypad scanner
    // ------------------------------------------------------------------------
    logic [c_DWELL_W-1:0] r_dwell;
    logic [1:0]           r_col_idx;
    logic [3:0]           r_key_cols;
    logic                 r_frame_hit;
    logic [3:0]           r_frame_code;
    logic                 r_prev_hit;
    logic [3:0]           r_prev_code;
    logic [c_DB_W-1:0]    r_same_cnt;
    logic                 r_held;
    logic                 r_key_valid;
    logic [3:0]           r_key_code;

    logic                 w_dwell_last;
    logic                 w_row_hit;
    logic [1:0]           w_row_idx;
    logic                 w_frame_hit;
    logic [3:0]           w_frame_code;
    logic                 w_same;
    logic [c_DB_W-1:0]    w_cnt_nxt;
    logic                 w_db_done;

    assign w_dwell_last = (r_dwell == c_DWELL_W'(SCAN_DIV - 1));
    assign w_row_hit    = |key_rows;

    always_comb begin
        w_row_idx = 2'd0;
        if (key_rows[0])      w_row_idx = 2'd0;
        else if (key_rows[1]) w_row_idx = 2'd1;
        else if (key_rows[2]) w_row_idx = 2'd2;
        else if (key_rows[3]) w_row_idx = 2'd3;
    end

    // An earlier column already seen in this frame outranks the current one.
    assign w_frame_hit  = r_frame_hit | w_row_hit;
    assign w_frame_code = r_frame_hit ? r_frame_code : {r_col_idx, w_row_idx};
    assign w_same       = (w_frame_hit == r_prev_hit) &&
                          (!w_frame_hit || (w_frame_code == r_prev_code));

    always_comb begin
        w_cnt_nxt = c_DB_W'(1);
        if (w_same) begin
            if (r_same_cnt == c_DB_W'(DEBOUNCE)) w_cnt_nxt = r_same_cnt;
            else                                 w_cnt_nxt = r_same_cnt + c_DB_W'(1);
        end
    end
    assign w_db_done = (w_cnt_nxt == c_DB_W'(DEBOUNCE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell      <= '0;
            r_col_idx    <= 2'd0;
            r_key_cols   <= 4'b0001;
            r_frame_hit  <= 1'b0;
            r_frame_code <= 4'd0;
            r_prev_hit   <= 1'b0;
            r_prev_code  <= 4'd0;
            r_same_cnt   <= '0;
            r_held       <= 1'b0;
            r_key_valid  <= 1'b0;
            r_key_code   <= 4'd0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_dwell_last) begin
                r_dwell    <= '0;
                r_key_cols <= {r_key_cols[2:0], r_key_cols[3]};
                r_col_idx  <= r_col_idx + 2'd1;
                if (r_col_idx == 2'd3) begin
                    r_frame_hit <= 1'b0;
                    r_prev_hit  <= w_frame_hit;
                    r_prev_code <= w_frame_code;
                    r_same_cnt  <= w_cnt_nxt;
                    if (w_db_done) begin
                        if (!r_held && w_frame_hit) begin
                            r_held      <= 1'b1;
                            r_key_valid <= 1'b1;
                            r_key_code  <= w_frame_code;
                        end else if (r_held && !w_frame_hit) begin
                            r_held <= 1'b0;
                        end
                    end
                end else if (!r_frame_hit && w_row_hit) begin
                    r_frame_hit  <= 1'b1;
                    r_frame_code <= {r_col_idx, w_row_idx};
                end
            end else begin
                r_dwell <= r_dwell + c_DWELL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command FSM, register file and ALU
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_res_valid;
    logic [WIDTH-1:0]    r_res_data;
    logic [3:0]          r_flags;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_dst;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [3:0]          r_key_snap;
    logic [WIDTH-1:0]    r_regs [DEPTH];

    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_result;
    logic                w_c;
    logic                w_v;
    logic [3:0]          w_flags;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
                if (c_SAT_EN && w_sum[WIDTH]) w_result = '1;
            end
            c_OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_c      = w_diff[WIDTH];
                w_v      = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
                if (c_SAT_EN && w_diff[WIDTH]) w_result = '0;
            end
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            c_OP_XOR: w_result = r_a ^ r_b;
            c_OP_SHL: begin
                w_result = {r_a[WIDTH-2:0], 1'b0};
                w_c      = r_a[WIDTH-1];
            end
            c_OP_SHR: begin
                w_result = {1'b0, r_a[WIDTH-1:1]};
                w_c      = r_a[0];
            end
            c_OP_LDK: w_result = WIDTH'(r_key_snap);
            default:  w_result = '0;
        endcase
    end

    assign w_flags = {(w_result == '0), w_result[WIDTH-1], w_c, w_v};

    // Operands are captured at accept, so src == dst write-back is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_flags     <= 4'd0;
            r_op        <= 3'd0;
            r_dst       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_key_snap  <= 4'd0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= cmd_op;
                        r_dst       <= cmd_dst;
                        r_a         <= r_regs[cmd_src_a];
                        r_b         <= r_regs[cmd_src_b];
                        r_key_snap  <= r_key_code;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_regs[r_dst] <= w_result;
                    r_res_data    <= w_result;
                    r_flags       <= w_flags;
                    r_res_valid   <= 1'b1;
                    r_state       <= S_WB;
                end
                S_WB: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign key_cols  = r_key_cols;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign cmd_ready = r_cmd_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_keypad_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_alu_datapath
// Brief    : Directed self-checking bench for keypad_alu_datapath.
// Revision : 1.0
// ============================================================================
module tb_keypad_alu_datapath;

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_OR  = 3'b011;
    localparam logic [2:0] c_XOR = 3'b100;
    localparam logic [2:0] c_SHL = 3'b101;
    localparam logic [2:0] c_SHR = 3'b110;
    localparam logic [2:0] c_LDK = 3'b111;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_rows;
    logic [3:0] key_cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [1:0] cmd_dst;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] flags;

    logic       pressed;
    logic [1:0] press_col;
    logic [3:0] press_rows;

    int checks;
    int errors;
    int kv_cnt;
    int exp_kv;

    logic [8:0] s_cmd [6];
    logic [7:0] s_res [6];
    logic [3:0] s_flg [6];

    keypad_alu_datapath #(
        .WIDTH    (8),
        .DEPTH    (4),
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .key_rows  (key_rows),
        .key_cols  (key_cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_dst   (cmd_dst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Keypad model: the pressed key's rows answer only while its column is driven.
    assign key_rows = (pressed && key_cols[press_col]) ? press_rows : 4'b0000;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press_key(input logic [1:0] col, input logic [3:0] rows, input logic [3:0] code);
        press_col  = col;
        press_rows = rows;
        pressed    = 1'b1;
        repeat (48) @(negedge clk);
        pressed = 1'b0;
        repeat (48) @(negedge clk);
        exp_kv++;
        chk("key_code", 32'(key_code), 32'(code));
        chk("key_count", kv_cnt, exp_kv);
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] a,
                          input logic [1:0] b, input logic [1:0] d,
                          input logic [7:0] exp_res, input logic [3:0] exp_flg);
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_ready_exec"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rv_exec"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_rv_wb"}, 32'(res_valid), 32'd1);
        chk({tag, "_ready_wb"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_data"}, 32'(res_data), 32'(exp_res));
        chk({tag, "_flags"}, 32'(flags), 32'(exp_flg));
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rv_low"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic [8:0] w;
        checks     = 0;
        errors     = 0;
        exp_kv     = 0;
        reset      = 1'b1;
        pressed    = 1'b0;
        press_col  = 2'd1;
        press_rows = 4'b0100;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_src_a  = 2'd0;
        cmd_src_b  = 2'd0;
        cmd_dst    = 2'd0;

        s_cmd[0] = {c_LDK, 2'd0, 2'd0, 2'd0}; s_res[0] = 8'h09; s_flg[0] = 4'b0000;
        s_cmd[1] = {c_ADD, 2'd0, 2'd0, 2'd1}; s_res[1] = 8'h12; s_flg[1] = 4'b0000;
`ifdef KALU_SAT_EN
        s_cmd[2] = {c_SUB, 2'd0, 2'd1, 2'd2}; s_res[2] = 8'h00; s_flg[2] = 4'b1010;
`else
        s_cmd[2] = {c_SUB, 2'd0, 2'd1, 2'd2}; s_res[2] = 8'hF7; s_flg[2] = 4'b0110;
`endif
        s_cmd[3] = {c_XOR, 2'd1, 2'd0, 2'd3}; s_res[3] = 8'h1B; s_flg[3] = 4'b0000;
        s_cmd[4] = {3'b010, 2'd3, 2'd1, 2'd3}; s_res[4] = 8'h12; s_flg[4] = 4'b0000;
        s_cmd[5] = {c_SHR, 2'd0, 2'd0, 2'd0}; s_res[5] = 8'h04; s_flg[5] = 4'b0010;

        repeat (3) @(negedge clk);
        chk("rst_cols", 32'(key_cols), 32'h1);
        chk("rst_kvalid", 32'(key_valid), 32'd0);
        chk("rst_kcode", 32'(key_code), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rvalid", 32'(res_valid), 32'd0);
        chk("rst_rdata", 32'(res_data), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);

        // Key 6 (column 1, row 2) pressed from the first frame after reset.
        reset   = 1'b0;
        pressed = 1'b1;
        repeat (4) @(negedge clk);
        chk("cols_rotate", 32'(key_cols), 32'h2);
        repeat (27) @(negedge clk);
        chk("kv_before", 32'(key_valid), 32'd0);
        @(negedge clk);
        chk("kv_pulse", 32'(key_valid), 32'd1);
        chk("kcode_6", 32'(key_code), 32'h6);
        @(negedge clk);
        chk("kv_one_cycle", 32'(key_valid), 32'd0);
        repeat (79) @(negedge clk);
        chk("hold_no_repeat", kv_cnt, 1);

        // Release two frames, one-frame press, gap, then a two-frame press.
        pressed = 1'b0;
        repeat (32) @(negedge clk);
        pressed = 1'b1;
        repeat (16) @(negedge clk);
        pressed = 1'b0;
        repeat (16) @(negedge clk);
        chk("short_press", kv_cnt, 1);
        pressed = 1'b1;
        repeat (31) @(negedge clk);
        chk("kv2_before", 32'(key_valid), 32'd0);
        @(negedge clk);
        chk("kv2_pulse", 32'(key_valid), 32'd1);
        chk("kcode2_6", 32'(key_code), 32'h6);
        pressed = 1'b0;
        repeat (48) @(negedge clk);
        exp_kv = 2;
        chk("kv2_count", kv_cnt, exp_kv);

        do_cmd("ldk6", c_LDK, 2'd0, 2'd0, 2'd1, 8'h06, 4'b0000);
        do_cmd("add_0c", c_ADD, 2'd1, 2'd1, 2'd2, 8'h0C, 4'b0000);

        // Build r0 = 0x7F from keys 7 and F, then r3 = 1 from key 1.
        press_key(2'd1, 4'b1000, 4'h7);
        do_cmd("ldk7", c_LDK, 2'd0, 2'd0, 2'd0, 8'h07, 4'b0000);
        do_cmd("shl_0e", c_SHL, 2'd0, 2'd0, 2'd0, 8'h0E, 4'b0000);
        do_cmd("shl_1c", c_SHL, 2'd0, 2'd0, 2'd0, 8'h1C, 4'b0000);
        do_cmd("shl_38", c_SHL, 2'd0, 2'd0, 2'd0, 8'h38, 4'b0000);
        do_cmd("shl_70", c_SHL, 2'd0, 2'd0, 2'd0, 8'h70, 4'b0000);
        press_key(2'd3, 4'b1000, 4'hF);
        do_cmd("ldkf", c_LDK, 2'd0, 2'd0, 2'd3, 8'h0F, 4'b0000);
        do_cmd("or_7f", c_OR, 2'd0, 2'd3, 2'd0, 8'h7F, 4'b0000);
        press_key(2'd0, 4'b1010, 4'h1);
        do_cmd("ldk1", c_LDK, 2'd0, 2'd0, 2'd3, 8'h01, 4'b0000);
        do_cmd("add_ovf", c_ADD, 2'd0, 2'd3, 2'd1, 8'h80, 4'b0101);
`ifdef KALU_SAT_EN
        do_cmd("add_carry", c_ADD, 2'd1, 2'd1, 2'd1, 8'hFF, 4'b0111);
`else
        do_cmd("add_carry", c_ADD, 2'd1, 2'd1, 2'd1, 8'h00, 4'b1011);
`endif
        do_cmd("xor_zero", c_XOR, 2'd2, 2'd2, 2'd2, 8'h00, 4'b1000);
`ifdef KALU_SAT_EN
        do_cmd("sub_borrow", c_SUB, 2'd2, 2'd3, 2'd2, 8'h00, 4'b1010);
`else
        do_cmd("sub_borrow", c_SUB, 2'd2, 2'd3, 2'd2, 8'hFF, 4'b0110);
`endif
        do_cmd("shr_c", c_SHR, 2'd3, 2'd3, 2'd3, 8'h00, 4'b1010);

        // Reset while a command sits in EXEC.
        cmd_valid = 1'b1;
        cmd_op    = c_ADD;
        cmd_src_a = 2'd0;
        cmd_src_b = 2'd0;
        cmd_dst   = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_mid_exec", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_rv", 32'(res_valid), 32'd0);
        chk("rst_mid_data", 32'(res_data), 32'd0);
        chk("rst_mid_kcode", 32'(key_code), 32'd0);
        chk("rst_mid_cols", 32'(key_cols), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rv", 32'(res_valid), 32'd0);
        do_cmd("regs01_zero", c_ADD, 2'd0, 2'd1, 2'd0, 8'h00, 4'b1000);
        do_cmd("regs23_zero", c_ADD, 2'd2, 2'd3, 2'd2, 8'h00, 4'b1000);
        do_cmd("ldk_none", c_LDK, 2'd0, 2'd0, 2'd1, 8'h00, 4'b1000);

        // Back-to-back stream with cmd_valid held high and fields changing.
        press_key(2'd2, 4'b0010, 4'h9);
        cmd_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            chk("stream_ready", 32'(cmd_ready), 32'(i % 3 == 0));
            chk("stream_rv", 32'(res_valid), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                chk("stream_data", 32'(res_data), 32'(s_res[i / 3]));
                chk("stream_flags", 32'(flags), 32'(s_flg[i / 3]));
            end
            w = (i % 3 == 0) ? s_cmd[i / 3] : 9'(i * 37 + 5);
            {cmd_op, cmd_src_a, cmd_src_b, cmd_dst} = w;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("stream_end_ready", 32'(cmd_ready), 32'd1);
        chk("stream_end_rv", 32'(res_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
